aemb_opsel: RTL and testbench

Operand-select stage feeding the single-cycle barrel shifter and its sibling execute units. Each advancing cycle it takes one decoded MicroBlaze instruction word plus register-file read data and produces registered rOPA, rOPB and rALT for the execute stage. It owns the IMM-prefix state for 32-bit immediates, forces r0 reads to zero, and can forward the in-flight writeback result.

---
 rtl/aemb_pkg.sv | 35 +++
 rtl/aemb_fwd.sv | 32 +++
 rtl/aemb_opsel.sv | 120 ++++++++++++
 tb/tb_aemb_opsel.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/aemb_pkg.sv
// Shared definitions for the aemb operand-select stage: opcodes, instruction
// field positions, reset constants and a small sign-extension helper.
package aemb_pkg;

  localparam logic [5:0]  OP_IMM = 6'h2C;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RD_HI    = 25;
  localparam int RD_LO    = 21;
  localparam int RA_HI    = 20;
  localparam int RA_LO    = 16;
  localparam int RB_HI    = 15;
  localparam int RB_LO    = 11;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int ALT_HI   = 10;
  localparam int ALT_LO   = 0;
  localparam int TYPEB    = 29;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [31:0] RST_OP   = 32'h0000_0000;
  localparam logic [10:0] RST_ALT  = 11'h000;
  localparam logic [4:0]  RST_RD   = 5'd0;
  localparam logic        RST_VLD  = 1'b0;
  localparam logic        RST_IMMF = 1'b0;
  localparam logic [15:0] RST_IMMH = 16'h0000;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/aemb_fwd.sv
// Source-operand selector: returns the register-file value for one source
// index, optionally replaced by the in-flight writeback result, and forced
// to zero when the index is r0. Forwarding is only present when AEMB_FWD_EN
// is defined; otherwise the writeback inputs are accepted but unused.
module aemb_fwd
  import aemb_pkg::*;
(
  input  logic [4:0]  i_idx,
  input  logic [31:0] i_reg,
  input  logic        i_wb_en,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_val
);

`ifndef AEMB_FWD_EN
  logic unused_wb;
  assign unused_wb = ^{i_wb_en, i_wb_rd, i_wb_dat};
`endif

  // r0 is applied last so it wins over any writeback match on index 0
  always_comb begin
    o_val = i_reg;
`ifdef AEMB_FWD_EN
    if (i_wb_en && (i_wb_rd == i_idx)) o_val = i_wb_dat;
`else
    o_val = i_reg;
`endif
    if (i_idx == REG_ZERO) o_val = ZERO_WORD;
  end

endmodule

// File: rtl/aemb_opsel.sv
// Operand-select stage: registers operand A, operand B, the alt field and the
// destination for the execute stage, and tracks the IMM prefix that supplies
// the upper half of a 32-bit immediate. Build option AEMB_FWD_EN enables
// writeback forwarding inside aemb_fwd.
module aemb_opsel
  import aemb_pkg::*;
(
  input  logic        gclk,
  input  logic        grst,
  input  logic        gena,
  input  logic [31:0] iINST,
  input  logic        iVLD,
  input  logic [31:0] iREGA,
  input  logic [31:0] iREGB,
  input  logic        iWB_EN,
  input  logic [4:0]  iWB_RD,
  input  logic [31:0] iWB_DAT,
  output logic [31:0] rOPA,
  output logic [31:0] rOPB,
  output logic [10:0] rALT,
  output logic [4:0]  rRD,
  output logic        rVLD
);

  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [10:0] alt_q, alt_d;
  logic [4:0]  rd_q, rd_d;
  logic        vld_q, vld_d;
  logic        immf_q, immf_d;
  logic [15:0] immh_q, immh_d;

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [15:0] imm_lo;
  logic        is_imm;

  assign imm_lo = iINST[IMM_HI:IMM_LO];
  assign is_imm = (iINST[OPC_HI:OPC_LO] == OP_IMM);

  aemb_fwd u_fwd_a (
    .i_idx    (iINST[RA_HI:RA_LO]),
    .i_reg    (iREGA),
    .i_wb_en  (iWB_EN),
    .i_wb_rd  (iWB_RD),
    .i_wb_dat (iWB_DAT),
    .o_val    (fwd_a)
  );

  aemb_fwd u_fwd_b (
    .i_idx    (iINST[RB_HI:RB_LO]),
    .i_reg    (iREGB),
    .i_wb_en  (iWB_EN),
    .i_wb_rd  (iWB_RD),
    .i_wb_dat (iWB_DAT),
    .o_val    (fwd_b)
  );

  // Next-state: IMM loads the high half and issues nothing, other valid
  // instructions issue and consume the prefix, bubbles only drop rVLD
  always_comb begin
    opa_d  = opa_q;
    opb_d  = opb_q;
    alt_d  = alt_q;
    rd_d   = rd_q;
    vld_d  = vld_q;
    immf_d = immf_q;
    immh_d = immh_q;
    if (gena) begin
      if (iVLD) begin
        if (is_imm) begin
          immh_d = imm_lo;
          immf_d = 1'b1;
          vld_d  = 1'b0;
        end else begin
          opa_d = fwd_a;
          if (iINST[TYPEB]) begin
            opb_d = immf_q ? {immh_q, imm_lo} : sext16(imm_lo);
          end else begin
            opb_d = fwd_b;
          end
          alt_d  = iINST[ALT_HI:ALT_LO];
          rd_d   = iINST[RD_HI:RD_LO];
          vld_d  = 1'b1;
          immf_d = 1'b0;
        end
      end else begin
        vld_d = 1'b0;
      end
    end
  end

  // State registers; reset clears everything, including a pending IMM
  always_ff @(posedge gclk) begin
    if (grst) begin
      opa_q  <= RST_OP;
      opb_q  <= RST_OP;
      alt_q  <= RST_ALT;
      rd_q   <= RST_RD;
      vld_q  <= RST_VLD;
      immf_q <= RST_IMMF;
      immh_q <= RST_IMMH;
    end else begin
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      alt_q  <= alt_d;
      rd_q   <= rd_d;
      vld_q  <= vld_d;
      immf_q <= immf_d;
      immh_q <= immh_d;
    end
  end

  assign rOPA = opa_q;
  assign rOPB = opb_q;
  assign rALT = alt_q;
  assign rRD  = rd_q;
  assign rVLD = vld_q;

endmodule

// File: tb/tb_aemb_opsel.sv
// Directed testbench for aemb_opsel: reset, immediate handling, IMM prefix
// across bubbles and stalls, r0 zeroing, forwarding (AEMB_FWD_EN) and reset
// of a pending IMM.
module tb_aemb_opsel;

  logic        gclk;
  logic        grst;
  logic        gena;
  logic [31:0] iINST;
  logic        iVLD;
  logic [31:0] iREGA;
  logic [31:0] iREGB;
  logic        iWB_EN;
  logic [4:0]  iWB_RD;
  logic [31:0] iWB_DAT;
  logic [31:0] rOPA;
  logic [31:0] rOPB;
  logic [10:0] rALT;
  logic [4:0]  rRD;
  logic        rVLD;

  int total;
  int bad;

  aemb_opsel dut (
    .gclk    (gclk),
    .grst    (grst),
    .gena    (gena),
    .iINST   (iINST),
    .iVLD    (iVLD),
    .iREGA   (iREGA),
    .iREGB   (iREGB),
    .iWB_EN  (iWB_EN),
    .iWB_RD  (iWB_RD),
    .iWB_DAT (iWB_DAT),
    .rOPA    (rOPA),
    .rOPB    (rOPB),
    .rALT    (rALT),
    .rRD     (rRD),
    .rVLD    (rVLD)
  );

  // Free-running pipeline clock
  initial begin
    gclk = 1'b0;
    forever #5 gclk = ~gclk;
  end

  function automatic logic [31:0] instB(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [15:0] imm);
    return {op, rd, ra, imm};
  endfunction

  function automatic logic [31:0] instA(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [4:0] rb,
                                        input logic [10:0] alt);
    return {op, rd, ra, rb, alt};
  endfunction

  // Drive one cycle of inputs, then sample just after the rising edge
  task automatic applyStimulus(input logic rst, input logic ena, input logic vld,
                               input logic [31:0] inst, input logic [31:0] rega,
                               input logic [31:0] regb, input logic wben,
                               input logic [4:0] wbrd, input logic [31:0] wbdat);
    grst    = rst;
    gena    = ena;
    iVLD    = vld;
    iINST   = inst;
    iREGA   = rega;
    iREGB   = regb;
    iWB_EN  = wben;
    iWB_RD  = wbrd;
    iWB_DAT = wbdat;
    @(posedge gclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] eOpa,
                             input logic [31:0] eOpb, input logic [10:0] eAlt,
                             input logic [4:0] eRd, input logic eVld);
    total++;
    assert (rOPA === eOpa) else begin
      bad++;
      $error("[TB] FAIL %s rOPA got=%h exp=%h", tag, rOPA, eOpa);
    end
    total++;
    assert (rOPB === eOpb) else begin
      bad++;
      $error("[TB] FAIL %s rOPB got=%h exp=%h", tag, rOPB, eOpb);
    end
    total++;
    assert (rALT === eAlt) else begin
      bad++;
      $error("[TB] FAIL %s rALT got=%h exp=%h", tag, rALT, eAlt);
    end
    total++;
    assert (rRD === eRd) else begin
      bad++;
      $error("[TB] FAIL %s rRD got=%0d exp=%0d", tag, rRD, eRd);
    end
    total++;
    assert (rVLD === eVld) else begin
      bad++;
      $error("[TB] FAIL %s rVLD got=%b exp=%b", tag, rVLD, eVld);
    end
  endtask

  // Directed sequence; each step drives one edge and checks the registered result
  initial begin
    logic [31:0] expFwdB;
    logic [31:0] expFwdA;
    total = 0;
    bad   = 0;
`ifdef AEMB_FWD_EN
    expFwdB = 32'h0000_0009;
    expFwdA = 32'h0000_0022;
`else
    expFwdB = 32'h0000_0007;
    expFwdA = 32'h0000_0011;
`endif

    applyStimulus(1'b1, 1'b0, 1'b1, instB(6'h19, 5'd1, 5'd2, 16'h0405),
                  32'h8000_0000, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("reset", 32'h0, 32'h0, 11'h000, 5'd0, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b1, instB(6'h19, 5'd1, 5'd2, 16'h0405),
                  32'h8000_0000, 32'hDEAD_DEAD, 1'b0, 5'd0, 32'h0);
    checkOutput("bsrli", 32'h8000_0000, 32'h0000_0405, 11'h405, 5'd1, 1'b1);

    applyStimulus(1'b0, 1'b1, 1'b1, instB(6'h2C, 5'd0, 5'd0, 16'hDEAD),
                  32'h1, 32'h2, 1'b0, 5'd0, 32'h0);
    checkOutput("imm_dead", 32'h8000_0000, 32'h0000_0405, 11'h405, 5'd1, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, instB(6'h19, 5'd9, 5'd9, 16'h0001),
                  32'h3, 32'h4, 1'b0, 5'd0, 32'h0);
    checkOutput("bubble", 32'h8000_0000, 32'h0000_0405, 11'h405, 5'd1, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b1, instB(6'h28, 5'd4, 5'd5, 16'hBEEF),
                  32'h0000_1234, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("deadbeef", 32'h0000_1234, 32'hDEAD_BEEF, 11'h6EF, 5'd4, 1'b1);

    applyStimulus(1'b0, 1'b1, 1'b1, instB(6'h28, 5'd6, 5'd0, 16'hFFFF),
                  32'h0000_9999, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("sext_ffff", 32'h0, 32'hFFFF_FFFF, 11'h7FF, 5'd6, 1'b1);

    applyStimulus(1'b0, 1'b1, 1'b1, instA(6'h00, 5'd7, 5'd0, 5'd3, 11'h000),
                  32'h0000_0055, 32'h0000_0007, 1'b1, 5'd3, 32'h0000_0009);
    checkOutput("fwd_b", 32'h0, expFwdB, 11'h000, 5'd7, 1'b1);

    applyStimulus(1'b0, 1'b1, 1'b1, instA(6'h00, 5'd8, 5'd5, 5'd0, 11'h123),
                  32'h0000_0011, 32'h0000_0033, 1'b1, 5'd5, 32'h0000_0022);
    checkOutput("fwd_a", expFwdA, 32'h0, 11'h123, 5'd8, 1'b1);

    applyStimulus(1'b0, 1'b1, 1'b1, instA(6'h00, 5'd9, 5'd0, 5'd0, 11'h000),
                  32'h0000_0044, 32'h0000_0066, 1'b1, 5'd0, 32'h0000_00AA);
    checkOutput("r0_prio", 32'h0, 32'h0, 11'h000, 5'd9, 1'b1);

    applyStimulus(1'b0, 1'b1, 1'b1, instB(6'h2C, 5'd0, 5'd0, 16'h1111),
                  32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("imm_1111", 32'h0, 32'h0, 11'h000, 5'd9, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b1, instB(6'h2C, 5'd0, 5'd0, 16'h2222),
                  32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("imm_2222", 32'h0, 32'h0, 11'h000, 5'd9, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b1, instB(6'h28, 5'd10, 5'd1, 16'h0001),
                  32'h0000_0077, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("last_imm", 32'h0000_0077, 32'h2222_0001, 11'h001, 5'd10, 1'b1);

    applyStimulus(1'b0, 1'b1, 1'b1, instB(6'h2C, 5'd0, 5'd0, 16'h1357),
                  32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("imm_1357", 32'h0000_0077, 32'h2222_0001, 11'h001, 5'd10, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, instB(6'h2C, 5'd0, 5'd0, 16'hFFFF),
                  32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("stall1", 32'h0000_0077, 32'h2222_0001, 11'h001, 5'd10, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, instB(6'h28, 5'd11, 5'd2, 16'h0F0F),
                  32'h0000_0088, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("stall2", 32'h0000_0077, 32'h2222_0001, 11'h001, 5'd10, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, instA(6'h00, 5'd12, 5'd3, 5'd4, 11'h055),
                  32'h0000_0099, 32'h0000_00AA, 1'b1, 5'd3, 32'h0000_00BB);
    checkOutput("stall3", 32'h0000_0077, 32'h2222_0001, 11'h001, 5'd10, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b1, instB(6'h28, 5'd12, 5'd3, 16'h2468),
                  32'h0000_ABCD, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("after_stall", 32'h0000_ABCD, 32'h1357_2468, 11'h468, 5'd12, 1'b1);

    applyStimulus(1'b0, 1'b1, 1'b1, instB(6'h2C, 5'd0, 5'd0, 16'h7777),
                  32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("imm_7777", 32'h0000_ABCD, 32'h1357_2468, 11'h468, 5'd12, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b1, instB(6'h28, 5'd3, 5'd3, 16'h1234),
                  32'h0000_1111, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("reset_imm", 32'h0, 32'h0, 11'h000, 5'd0, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b1, instB(6'h28, 5'd13, 5'd4, 16'h8000),
                  32'h0000_0005, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("sext_8000", 32'h0000_0005, 32'hFFFF_8000, 11'h000, 5'd13, 1'b1);

    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("final_bubble", 32'h0000_0005, 32'hFFFF_8000, 11'h000, 5'd13, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
